// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage buffers.
// Payload structs are packed so they can be passed straight through a stage's data port.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // ADDI x0, x0, 0: the canonical RISC-V NOP used as the IF/ID bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } if_id_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [7:0]  ctrl;
    } id_ex_payload_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [7:0]  ctrl;
    } ex_mem_payload_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wb_data;
        logic        wb_en;
    } mem_wb_payload_t;

    localparam if_id_payload_t IF_ID_BUBBLE = '{pc: 32'h0, instruction: NOP_INSTR};

    function automatic logic [1:0] state_occupancy(input stage_state_e st);
        case (st)
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a one-entry skid buffer, flush-to-bubble and a
// saturating stall counter. up_ready_o comes only from registered state (plus rst).
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0,
    parameter int unsigned           CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_c,
    input  logic                  stall_c,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i,
    output logic [DATA_WIDTH-1:0] dn_data_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    stage_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;

    logic acc;
    logic rdy;
    logic stall_inc;

    assign up_ready_o = (state_q != FULL) & ~rst;
    assign acc        = up_valid_i & up_ready_o;
    assign rdy        = dn_ready_i & ~stall_c;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_c) begin
            state_d = EMPTY;
            main_d  = FLUSH_VALUE;
            skid_d  = FLUSH_VALUE;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = up_data_i;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (acc && rdy) begin
                        main_d = up_data_i;
                    end else if (acc) begin
                        skid_d  = up_data_i;
                        state_d = FULL;
                    end else if (rdy) begin
                        main_d  = FLUSH_VALUE;
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // up_ready_o is low here, so no new payload can arrive.
                    if (rdy) begin
                        main_d  = skid_q;
                        skid_d  = FLUSH_VALUE;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = FLUSH_VALUE;
                    skid_d  = FLUSH_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_VALUE;
            skid_q  <= FLUSH_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign dn_valid_o  = (state_q != EMPTY);
    assign dn_data_o   = main_q;
    assign occupancy_o = state_occupancy(state_q);

    // Flush cycles are not counted as stalls even if downstream was not ready.
    assign stall_inc = dn_valid_o & ~rdy & ~flush_c & ~rst;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage configured as an IF/ID stage with a 3-bit stall counter.
module tb_pipe_skid_stage;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 3;
    localparam logic [DW-1:0] FLUSH = 64'h0000_0000_0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_c;
    logic          stall_c;
    logic          up_valid_i;
    logic          up_ready_o;
    logic [DW-1:0] up_data_i;
    logic          dn_valid_o;
    logic          dn_ready_i;
    logic [DW-1:0] dn_data_o;
    logic [1:0]    occupancy_o;
    logic [CW-1:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_WIDTH  (DW),
        .FLUSH_VALUE (FLUSH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_c     (flush_c),
        .stall_c     (stall_c),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_data_i   (up_data_i),
        .dn_valid_o  (dn_valid_o),
        .dn_ready_i  (dn_ready_i),
        .dn_data_o   (dn_data_o),
        .occupancy_o (occupancy_o),
        .stall_cnt_o (stall_cnt_o)
    );

    // Invariants sampled on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (occupancy_o > 2'd2) begin
                failures++;
                $display("FAIL inv_occupancy: got %0d, want <= 2", occupancy_o);
            end
            if (!dn_valid_o && (dn_data_o !== FLUSH)) begin
                failures++;
                $display("FAIL inv_bubble: got %h, want %h", dn_data_o, FLUSH);
            end
            if (up_valid_i && up_ready_o && !up_ready_o) begin
                failures++;
                $display("FAIL inv_acc_ready: acc while not ready");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush_c = 1'b0; stall_c = 1'b0;
        up_valid_i = 1'b0; up_data_i = '0; dn_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_c = 1'b0; stall_c = 1'b0;
        up_valid_i = 1'b0; up_data_i = '0; dn_ready_i = 1'b0;
        step();
        checks++;
        if (up_ready_o !== 1'b0) begin
            failures++; $display("FAIL reset_up_ready_in_rst: got %b, want 0", up_ready_o);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (up_ready_o !== 1'b1) begin
            failures++; $display("FAIL reset_up_ready: got %b, want 1", up_ready_o);
        end
        checks++;
        if (dn_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_dn_valid: got %b, want 0", dn_valid_o);
        end
        checks++;
        if (dn_data_o !== FLUSH) begin
            failures++; $display("FAIL reset_dn_data: got %h, want %h", dn_data_o, FLUSH);
        end
        checks++;
        if (occupancy_o !== 2'd0 || stall_cnt_o !== 3'd0) begin
            failures++;
            $display("FAIL reset_occ_cnt: got occ=%0d cnt=%0d, want 0/0", occupancy_o, stall_cnt_o);
        end
    endtask

    task automatic test_streaming();
        do_reset();
        dn_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            up_valid_i = 1'b1;
            up_data_i  = DW'(i);
            step();
            checks++;
            if (dn_valid_o !== 1'b1 || dn_data_o !== DW'(i)) begin
                failures++;
                $display("FAIL stream_data[%0d]: got v=%b d=%h, want v=1 d=%h",
                         i, dn_valid_o, dn_data_o, DW'(i));
            end
            checks++;
            if (up_ready_o !== 1'b1 || occupancy_o !== 2'd1) begin
                failures++;
                $display("FAIL stream_ready_occ[%0d]: got rdy=%b occ=%0d, want 1/1",
                         i, up_ready_o, occupancy_o);
            end
        end
        up_valid_i = 1'b0;
        step();
        checks++;
        if (dn_valid_o !== 1'b0 || stall_cnt_o !== 3'd0) begin
            failures++;
            $display("FAIL stream_end: got v=%b cnt=%0d, want 0/0", dn_valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_skid();
        do_reset();
        dn_ready_i = 1'b1; up_valid_i = 1'b1; up_data_i = 64'hA;
        step();
        dn_ready_i = 1'b0; up_data_i = 64'hB;
        step();
        checks++;
        if (occupancy_o !== 2'd2 || up_ready_o !== 1'b0 || dn_data_o !== 64'hA) begin
            failures++;
            $display("FAIL skid_full: got occ=%0d rdy=%b d=%h, want 2/0/a",
                     occupancy_o, up_ready_o, dn_data_o);
        end
        checks++;
        if (stall_cnt_o !== 3'd1) begin
            failures++; $display("FAIL skid_stall_cnt: got %0d, want 1", stall_cnt_o);
        end
        dn_ready_i = 1'b1; up_data_i = 64'hC;
        step();
        checks++;
        if (dn_data_o !== 64'hB || occupancy_o !== 2'd1 || up_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL skid_second: got d=%h occ=%0d rdy=%b, want b/1/1",
                     dn_data_o, occupancy_o, up_ready_o);
        end
        step();
        checks++;
        if (dn_data_o !== 64'hC || dn_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL skid_third: got v=%b d=%h, want 1/c", dn_valid_o, dn_data_o);
        end
        up_valid_i = 1'b0;
        step();
        checks++;
        if (dn_valid_o !== 1'b0 || stall_cnt_o !== 3'd1) begin
            failures++;
            $display("FAIL skid_drain: got v=%b cnt=%0d, want 0/1", dn_valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_flush_full();
        do_reset();
        dn_ready_i = 1'b1; up_valid_i = 1'b1; up_data_i = 64'h11;
        step();
        dn_ready_i = 1'b0; up_data_i = 64'h22;
        step();
        flush_c = 1'b1; up_data_i = 64'h33;
        step();
        flush_c = 1'b0;
        checks++;
        if (dn_valid_o !== 1'b0 || dn_data_o !== FLUSH) begin
            failures++;
            $display("FAIL flush_out: got v=%b d=%h, want 0/%h", dn_valid_o, dn_data_o, FLUSH);
        end
        checks++;
        if (occupancy_o !== 2'd0 || up_ready_o !== 1'b1 || stall_cnt_o !== 3'd1) begin
            failures++;
            $display("FAIL flush_state: got occ=%0d rdy=%b cnt=%0d, want 0/1/1",
                     occupancy_o, up_ready_o, stall_cnt_o);
        end
        up_valid_i = 1'b0; dn_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dn_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_leak[%0d]: got v=%b d=%h, want v=0", i, dn_valid_o, dn_data_o);
            end
        end
    endtask

    task automatic test_stall_empty();
        do_reset();
        stall_c = 1'b1; dn_ready_i = 1'b1; up_valid_i = 1'b1; up_data_i = 64'h55;
        step();
        checks++;
        if (dn_valid_o !== 1'b1 || dn_data_o !== 64'h55 || stall_cnt_o !== 3'd0) begin
            failures++;
            $display("FAIL stall_empty_acc: got v=%b d=%h cnt=%0d, want 1/55/0",
                     dn_valid_o, dn_data_o, stall_cnt_o);
        end
        up_data_i = 64'h66;
        step();
        checks++;
        if (occupancy_o !== 2'd2 || dn_data_o !== 64'h55 || stall_cnt_o !== 3'd1) begin
            failures++;
            $display("FAIL stall_busy_skid: got occ=%0d d=%h cnt=%0d, want 2/55/1",
                     occupancy_o, dn_data_o, stall_cnt_o);
        end
        stall_c = 1'b0; up_valid_i = 1'b0;
        step();
        checks++;
        if (dn_data_o !== 64'h66 || occupancy_o !== 2'd1) begin
            failures++;
            $display("FAIL stall_release: got d=%h occ=%0d, want 66/1", dn_data_o, occupancy_o);
        end
    endtask

    task automatic test_stall_saturation();
        int exp_cnt;
        do_reset();
        dn_ready_i = 1'b1; up_valid_i = 1'b1; up_data_i = 64'h44;
        step();
        up_valid_i = 1'b0; stall_c = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_cnt = (i > 7) ? 7 : i;
            checks++;
            if (stall_cnt_o !== CW'(exp_cnt)) begin
                failures++;
                $display("FAIL sat_cnt[%0d]: got %0d, want %0d", i, stall_cnt_o, exp_cnt);
            end
        end
        flush_c = 1'b1;
        step();
        flush_c = 1'b0; stall_c = 1'b0;
        checks++;
        if (stall_cnt_o !== 3'd7 || dn_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL sat_after_flush: got cnt=%0d v=%b, want 7/0", stall_cnt_o, dn_valid_o);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (stall_cnt_o !== 3'd0) begin
            failures++; $display("FAIL sat_after_rst: got %0d, want 0", stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dn_ready_i = 1'b1; up_valid_i = 1'b1; up_data_i = 64'h11;
        step();
        dn_ready_i = 1'b0; up_data_i = 64'h22;
        step();
        rst = 1'b1; up_data_i = 64'h77;
        #1;
        checks++;
        if (up_ready_o !== 1'b0) begin
            failures++; $display("FAIL rstmid_ready_in_rst: got %b, want 0", up_ready_o);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (dn_valid_o !== 1'b0 || dn_data_o !== FLUSH || occupancy_o !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_state: got v=%b d=%h occ=%0d, want 0/%h/0",
                     dn_valid_o, dn_data_o, occupancy_o, FLUSH);
        end
        checks++;
        if (up_ready_o !== 1'b1 || stall_cnt_o !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_ready_cnt: got rdy=%b cnt=%0d, want 1/0", up_ready_o, stall_cnt_o);
        end
        up_data_i = 64'h88; dn_ready_i = 1'b1;
        step();
        checks++;
        if (dn_valid_o !== 1'b1 || dn_data_o !== 64'h88) begin
            failures++;
            $display("FAIL rstmid_first: got v=%b d=%h, want 1/88", dn_valid_o, dn_data_o);
        end
        up_valid_i = 1'b0;
        step();
    endtask

    task automatic test_drain();
        do_reset();
        dn_ready_i = 1'b1; up_valid_i = 1'b1; up_data_i = 64'h5;
        step();
        checks++;
        if (dn_data_o !== 64'h5 || dn_valid_o !== 1'b1) begin
            failures++; $display("FAIL drain_load: got v=%b d=%h, want 1/5", dn_valid_o, dn_data_o);
        end
        up_valid_i = 1'b0;
        step();
        checks++;
        if (dn_valid_o !== 1'b0 || dn_data_o[31:0] !== 32'h0000_0013) begin
            failures++;
            $display("FAIL drain_bubble: got v=%b instr=%h, want 0/00000013",
                     dn_valid_o, dn_data_o[31:0]);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush_full();
        test_stall_empty();
        test_stall_saturation();
        test_reset_mid();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
